// File: rtl/uart_phy_cfg.sv
// uart_phy_cfg: runtime-configurable UART PHY.
//   Programmable baud divisor, 5..8 data bits, none/even/odd parity, 1/2 stop
//   bits. RX uses 16x oversampling with a 3-sample majority vote per bit and
//   reports parity, framing and break errors alongside each received byte.
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   cfg_div             oversample tick period minus 1 (values < 3 act as 3)
//   cfg_data_bits       data bits minus 5
//   cfg_parity          0/3 none, 1 even, 2 odd
//   cfg_stop2           TX sends two stop bits
//   uart_tx, uart_rx    board pins (uart_rx is asynchronous)
//   tx_data/valid/ready byte handshake into the transmitter
//   rx_data/valid       received byte with one-cycle qualifier
//   rx_parity_err, rx_frame_err, rx_break   per-frame status, held until next rx_valid
module uart_phy_cfg #(
    parameter int CLK_HZ      = 100000000,
    parameter int RESET_DIV   = 53,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_div,
    input  logic [1:0]  cfg_data_bits,
    input  logic [1:0]  cfg_parity,
    input  logic        cfg_stop2,
    output logic        uart_tx,
    input  logic        uart_rx,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_parity_err,
    output logic        rx_frame_err,
    output logic        rx_break
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // CLK_HZ and RESET_DIV are descriptive only; referenced here so they stay visible.
    localparam int unused_doc_params = CLK_HZ ^ RESET_DIV;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd3) ? 16'd3 : d;
    endfunction

    // ---------------- transmitter ----------------
    state_t      tx_state, tx_next;
    logic [15:0] tx_div, tx_pcnt;
    logic [3:0]  tx_sub;
    logic [2:0]  tx_bit, tx_last;
    logic [1:0]  tx_par_mode;
    logic        tx_stop2, tx_stop_cnt, tx_par_bit;
    logic [7:0]  tx_shift, tx_masked;
    logic        tx_tick, tx_bit_end, tx_par_en;

    assign tx_masked  = tx_data & (8'hFF >> (2'd3 - cfg_data_bits));
    assign tx_tick    = (tx_pcnt == tx_div);
    assign tx_bit_end = tx_tick && (tx_sub == 4'd15);
    assign tx_par_en  = (tx_par_mode == 2'd1) || (tx_par_mode == 2'd2);
    assign tx_ready   = (tx_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= S_IDLE;
        else      tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_valid) tx_next = S_START;
            S_START:  if (tx_bit_end) tx_next = S_DATA;
            S_DATA:   if (tx_bit_end && (tx_bit == tx_last)) tx_next = tx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
            S_STOP:   if (tx_bit_end && (!tx_stop2 || tx_stop_cnt)) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // Config and byte are captured on accept so mid-frame cfg changes only
    // affect the next frame. Parity bit is precomputed from the masked byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_div      <= 16'd3;
            tx_pcnt     <= '0;
            tx_sub      <= '0;
            tx_bit      <= '0;
            tx_last     <= 3'd7;
            tx_par_mode <= '0;
            tx_stop2    <= 1'b0;
            tx_stop_cnt <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_shift    <= '0;
        end else if (tx_state == S_IDLE) begin
            tx_pcnt     <= '0;
            tx_sub      <= '0;
            tx_bit      <= '0;
            tx_stop_cnt <= 1'b0;
            if (tx_valid) begin
                tx_div      <= clamp_div(cfg_div);
                tx_last     <= {1'b0, cfg_data_bits} + 3'd4;
                tx_par_mode <= cfg_parity;
                tx_stop2    <= cfg_stop2;
                tx_shift    <= tx_masked;
                tx_par_bit  <= (^tx_masked) ^ (cfg_parity == 2'd2);
            end
        end else begin
            tx_pcnt <= tx_tick ? 16'd0 : tx_pcnt + 16'd1;
            if (tx_tick) tx_sub <= tx_sub + 4'd1;
            if (tx_bit_end) begin
                if (tx_state == S_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
                if (tx_state == S_STOP) tx_stop_cnt <= 1'b1;
            end
        end
    end

    // Line level decoded straight from state so reset forces idle-high at once.
    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            S_START:  uart_tx = 1'b0;
            S_DATA:   uart_tx = tx_shift[0];
            S_PARITY: uart_tx = tx_par_bit;
            default:  uart_tx = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic [SYNC_N-1:0] rx_sync;
    logic        rx_s, rx_prev, rx_fall;
    state_t      rx_state, rx_next;
    logic [15:0] rx_div, rx_pcnt;
    logic [3:0]  rx_sub;
    logic [2:0]  rx_bit, rx_last;
    logic [1:0]  rx_par_mode;
    logic        rx_s7, rx_s8, rx_par_sample, rx_zero, rx_maj;
    logic [7:0]  rx_shift, rx_aligned;
    logic        rx_tick, rx_mid, rx_end, rx_par_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_N-2:0], uart_rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s       = rx_sync[SYNC_N-1];
    assign rx_fall    = rx_prev && !rx_s;
    assign rx_tick    = (rx_pcnt == rx_div);
    assign rx_mid     = rx_tick && (rx_sub == 4'd9);
    assign rx_end     = rx_tick && (rx_sub == 4'd15);
    assign rx_par_en  = (rx_par_mode == 2'd1) || (rx_par_mode == 2'd2);
    // Third vote is the live sample at sub-tick 9.
    assign rx_maj     = (rx_s7 & rx_s8) | (rx_s7 & rx_s) | (rx_s8 & rx_s);
    // Data shifts in from the top, so an N-bit frame sits in the upper N bits.
    assign rx_aligned = rx_shift >> (3'd7 - rx_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= S_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_next = S_START;
            S_START:  if (rx_mid && rx_maj) rx_next = S_IDLE;
                      else if (rx_end) rx_next = S_DATA;
            S_DATA:   if (rx_end && (rx_bit == rx_last)) rx_next = rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_end) rx_next = S_STOP;
            S_STOP:   if (rx_mid) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    // rx_zero stays set only while every data/parity sample has been 0; the
    // stop sample then decides break.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_div        <= 16'd3;
            rx_pcnt       <= '0;
            rx_sub        <= '0;
            rx_bit        <= '0;
            rx_last       <= 3'd7;
            rx_par_mode   <= '0;
            rx_s7         <= 1'b1;
            rx_s8         <= 1'b1;
            rx_par_sample <= 1'b0;
            rx_zero       <= 1'b1;
            rx_shift      <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_pcnt <= '0;
            rx_sub  <= '0;
            rx_bit  <= '0;
            rx_zero <= 1'b1;
            if (rx_fall) begin
                rx_div      <= clamp_div(cfg_div);
                rx_last     <= {1'b0, cfg_data_bits} + 3'd4;
                rx_par_mode <= cfg_parity;
            end
        end else begin
            rx_pcnt <= rx_tick ? 16'd0 : rx_pcnt + 16'd1;
            if (rx_tick) rx_sub <= rx_sub + 4'd1;
            if (rx_tick && (rx_sub == 4'd7)) rx_s7 <= rx_s;
            if (rx_tick && (rx_sub == 4'd8)) rx_s8 <= rx_s;
            if (rx_mid) begin
                if (rx_state == S_DATA) begin
                    rx_shift <= {rx_maj, rx_shift[7:1]};
                    rx_zero  <= rx_zero & ~rx_maj;
                end
                if (rx_state == S_PARITY) begin
                    rx_par_sample <= rx_maj;
                    rx_zero       <= rx_zero & ~rx_maj;
                end
            end
            if (rx_end && (rx_state == S_DATA)) rx_bit <= rx_bit + 3'd1;
        end
    end

    // Results publish at mid stop bit; outputs hold until the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((rx_state == S_STOP) && rx_mid) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_aligned;
                rx_parity_err <= rx_par_en && (((^rx_aligned) ^ rx_par_sample) != (rx_par_mode == 2'd2));
                rx_frame_err  <= !rx_maj;
                rx_break      <= rx_zero && !rx_maj;
            end
        end
    end

endmodule
